control_sequencer: RTL and testbench

- Hardwired control unit driving every datapath, bus-encoder, register-select and memory strobe in the CPU top level.
- Steps fetch (PC→MAR, RAM read, MDR→IR), decodes IR[31:27], sequences the per-instruction execute steps, then returns to fetch.
- Sits directly upstream of the datapath and the 512x32 RAM; its outputs are the top-level control nets.

---
 rtl/cpu_ctrl_pkg.sv | 118 +++++++++++
 rtl/control_sequencer_mem_wait_counter.sv | 28 ++
 rtl/control_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired CPU control sequencer: opcode map,
// FSM state encoding, instruction classes and small decode helpers.
package cpu_ctrl_pkg;

  localparam int OP_W = 5;

  // Instruction opcodes (IR[31:27])
  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10101;
  localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b11001;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  // ALU code used for address, immediate-add and branch-target arithmetic
  localparam logic [OP_W-1:0] ALU_ADD = OP_ADD;

  // Sequencer states: fetch F0/F1/FW/F2, execute E0..E4 plus the ld data-read wait EW
  typedef enum logic [3:0] {
    ST_RESET,
    ST_F0,
    ST_F1,
    ST_FW,
    ST_F2,
    ST_E0,
    ST_E1,
    ST_E2,
    ST_E3,
    ST_EW,
    ST_E4,
    ST_HALT
  } state_t;

  // Instructions grouped by identical control-step sequences
  typedef enum logic [3:0] {
    CL_NONE,
    CL_ALU_R,
    CL_ALU_I,
    CL_LDI,
    CL_LD,
    CL_ST,
    CL_MULDIV,
    CL_UNARY,
    CL_BR,
    CL_JR,
    CL_IN,
    CL_OUT,
    CL_MFLO,
    CL_MFHI,
    CL_HALT
  } op_class_t;

  function automatic op_class_t op_class(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:    return CL_ALU_R;
      OP_ADDI, OP_ANDI, OP_ORI:           return CL_ALU_I;
      OP_LDI:                             return CL_LDI;
      OP_LD:                              return CL_LD;
      OP_ST:                              return CL_ST;
      OP_DIV, OP_MUL:                     return CL_MULDIV;
      OP_NEG, OP_NOT:                     return CL_UNARY;
      OP_BR:                              return CL_BR;
      OP_JR:                              return CL_JR;
      OP_IN:                              return CL_IN;
      OP_OUT:                             return CL_OUT;
      OP_MFLO:                            return CL_MFLO;
      OP_MFHI:                            return CL_MFHI;
      OP_HALT:                            return CL_HALT;
      default:                            return CL_NONE;
    endcase
  endfunction

  // Number of execute steps, not counting the extra ld memory-wait cycles
  function automatic logic [2:0] exec_steps(input op_class_t c);
    case (c)
      CL_ALU_R, CL_ALU_I, CL_LDI:          return 3'd3;
      CL_LD, CL_ST:                        return 3'd5;
      CL_MULDIV, CL_BR:                    return 3'd4;
      CL_UNARY:                            return 3'd2;
      CL_JR, CL_IN, CL_OUT,
      CL_MFLO, CL_MFHI:                    return 3'd1;
      default:                             return 3'd0;
    endcase
  endfunction

  // Immediate forms run the ALU operation of their register counterpart
  function automatic logic [OP_W-1:0] alu_code(input logic [OP_W-1:0] op);
    case (op)
      OP_ADDI: return OP_ADD;
      OP_ANDI: return OP_AND;
      OP_ORI:  return OP_OR;
      default: return op;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_mem_wait_counter.sv
// Loadable down-counter of RAM read wait cycles; shared by the instruction
// fetch read and the ld data read. 'last' marks the final wait cycle.
module mem_wait_counter #(
  parameter int MEM_WAIT = 1
) (
  input  logic Clock,
  input  logic clear,
  input  logic load,
  input  logic dec,
  output logic last
);

  logic [1:0] cnt;

  // Load with the wait length on entry to a read, count down while waiting
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      cnt <= 2'd0;
    end else if (load) begin
      cnt <= 2'(MEM_WAIT);
    end else if (dec && (cnt != 2'd0)) begin
      cnt <= cnt - 2'd1;
    end
  end

  assign last = (cnt == 2'd1);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch, decode of IR[31:27], per-instruction
// execute steps, and halt. All control nets are Moore-decoded from the
// state and the opcode latched at the end of F2 (br PCin also follows
// con_ff_bit in its final step). MEM_WAIT must lie in 0..3.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 5,
  parameter int MEM_WAIT     = 1
) (
  input  logic                    Clock,
  input  logic                    clear,
  input  logic [DATA_WIDTH-1:0]   IR,
  input  logic                    con_ff_bit,
  input  logic                    Stop,
  output logic                    Run,
  output logic                    HIout,
  output logic                    LOout,
  output logic                    Zhi_out,
  output logic                    Zlo_out,
  output logic                    PCout,
  output logic                    MDRout,
  output logic                    Inport_out,
  output logic                    Cout,
  output logic                    MARin,
  output logic                    Zin,
  output logic                    PCin,
  output logic                    MDRin,
  output logic                    IRin,
  output logic                    Yin,
  output logic                    HIin,
  output logic                    LOin,
  output logic                    outport_in,
  output logic                    CONin,
  output logic                    Gra,
  output logic                    Grb,
  output logic                    Grc,
  output logic                    Rin,
  output logic                    Rout,
  output logic                    BAout,
  output logic [OPCODE_WIDTH-1:0] opcode,
  output logic                    IncPC,
  output logic                    Mem_Read,
  output logic                    Mem_Write,
  output logic                    Mem_enable512x32
);

  state_t                  state;
  state_t                  state_next;
  state_t                  boundary_state;
  logic [OPCODE_WIDTH-1:0] ir_op;
  logic [OPCODE_WIDTH-1:0] op_q;
  op_class_t               cls;
  op_class_t               ir_cls;
  logic [2:0]              steps;
  logic                    wait_load;
  logic                    wait_dec;
  logic                    wait_last;
  logic                    unused_ir_bits;

  assign ir_op          = IR[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign unused_ir_bits = ^IR[DATA_WIDTH-OPCODE_WIDTH-1:0];
  assign ir_cls         = op_class(ir_op);
  assign cls            = op_class(op_q);
  assign steps          = exec_steps(cls);

  // Stop only matters in the last cycle of an instruction
  assign boundary_state = Stop ? ST_HALT : ST_F0;

  // Read waits start after F1 (fetch) or E3 (ld data read)
  assign wait_load = (state == ST_F1) || ((state == ST_E3) && (cls == CL_LD));
  assign wait_dec  = (state == ST_FW) || (state == ST_EW);

  mem_wait_counter #(
    .MEM_WAIT (MEM_WAIT)
  ) u_wait (
    .Clock (Clock),
    .clear (clear),
    .load  (wait_load),
    .dec   (wait_dec),
    .last  (wait_last)
  );

  // State register and opcode latch; opcode captured on the F2 -> E0 edge
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state <= ST_RESET;
      op_q  <= '0;
    end else begin
      state <= state_next;
      if (state == ST_F2) begin
        op_q <= ir_op;
      end
    end
  end

  // Next-state sequencing through fetch, execute steps and halt
  always_comb begin
    state_next = state;
    case (state)
      ST_RESET: state_next = ST_F0;
      ST_F0:    state_next = ST_F1;
      ST_F1:    state_next = (MEM_WAIT == 0) ? ST_F2 : ST_FW;
      ST_FW:    state_next = wait_last ? ST_F2 : ST_FW;
      ST_F2: begin
        if (ir_cls == CL_HALT) begin
          state_next = ST_HALT;
        end else if (exec_steps(ir_cls) == 3'd0) begin
          state_next = boundary_state;
        end else begin
          state_next = ST_E0;
        end
      end
      ST_E0:    state_next = (steps == 3'd1) ? boundary_state : ST_E1;
      ST_E1:    state_next = (steps == 3'd2) ? boundary_state : ST_E2;
      ST_E2:    state_next = (steps == 3'd3) ? boundary_state : ST_E3;
      ST_E3: begin
        if (cls == CL_LD) begin
          state_next = (MEM_WAIT == 0) ? ST_E4 : ST_EW;
        end else begin
          state_next = (steps == 3'd4) ? boundary_state : ST_E4;
        end
      end
      ST_EW:    state_next = wait_last ? ST_E4 : ST_EW;
      ST_E4:    state_next = boundary_state;
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_RESET;
    endcase
  end

  // Control-net decode from state and latched opcode
  always_comb begin
    Run              = 1'b0;
    HIout            = 1'b0;
    LOout            = 1'b0;
    Zhi_out          = 1'b0;
    Zlo_out          = 1'b0;
    PCout            = 1'b0;
    MDRout           = 1'b0;
    Inport_out       = 1'b0;
    Cout             = 1'b0;
    MARin            = 1'b0;
    Zin              = 1'b0;
    PCin             = 1'b0;
    MDRin            = 1'b0;
    IRin             = 1'b0;
    Yin              = 1'b0;
    HIin             = 1'b0;
    LOin             = 1'b0;
    outport_in       = 1'b0;
    CONin            = 1'b0;
    Gra              = 1'b0;
    Grb              = 1'b0;
    Grc              = 1'b0;
    Rin              = 1'b0;
    Rout             = 1'b0;
    BAout            = 1'b0;
    opcode           = '0;
    IncPC            = 1'b0;
    Mem_Read         = 1'b0;
    Mem_Write        = 1'b0;
    Mem_enable512x32 = 1'b0;

    Run = (state != ST_RESET) && (state != ST_HALT);

    case (state)
      ST_F0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      ST_F1: begin
        Zlo_out = 1'b1; PCin = 1'b1;
        Mem_Read = 1'b1; Mem_enable512x32 = 1'b1;
        MDRin = (MEM_WAIT == 0);
      end
      ST_FW: begin
        Mem_Read = 1'b1; Mem_enable512x32 = 1'b1;
        MDRin = wait_last;
      end
      ST_F2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      ST_E0: begin
        case (cls)
          CL_ALU_R, CL_ALU_I: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CL_LDI, CL_LD, CL_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          CL_MULDIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CL_UNARY: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op_q; end
          CL_BR: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          CL_JR: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          CL_IN: begin Inport_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_OUT: begin Gra = 1'b1; Rout = 1'b1; outport_in = 1'b1; end
          CL_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      ST_E1: begin
        case (cls)
          CL_ALU_R: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = alu_code(op_q); end
          CL_ALU_I: begin Cout = 1'b1; Zin = 1'b1; opcode = alu_code(op_q); end
          CL_LDI, CL_LD, CL_ST: begin Cout = 1'b1; Zin = 1'b1; opcode = ALU_ADD; end
          CL_MULDIV: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op_q; end
          CL_UNARY: begin Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_BR: begin PCout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      ST_E2: begin
        case (cls)
          CL_ALU_R, CL_ALU_I, CL_LDI: begin Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_LD, CL_ST: begin Zlo_out = 1'b1; MARin = 1'b1; end
          CL_MULDIV: begin Zlo_out = 1'b1; LOin = 1'b1; end
          CL_BR: begin Cout = 1'b1; Zin = 1'b1; opcode = ALU_ADD; end
          default: ;
        endcase
      end
      ST_E3: begin
        case (cls)
          CL_LD: begin
            Mem_Read = 1'b1; Mem_enable512x32 = 1'b1;
            MDRin = (MEM_WAIT == 0);
          end
          CL_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          CL_MULDIV: begin Zhi_out = 1'b1; HIin = 1'b1; end
          CL_BR: begin Zlo_out = 1'b1; PCin = con_ff_bit; end
          default: ;
        endcase
      end
      ST_EW: begin
        Mem_Read = 1'b1; Mem_enable512x32 = 1'b1;
        MDRin = wait_last;
      end
      ST_E4: begin
        case (cls)
          CL_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_ST: begin Mem_Write = 1'b1; Mem_enable512x32 = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: instance 0 uses MEM_WAIT=1,
// instance 1 uses MEM_WAIT=2. Control nets are packed into one word per
// cycle and compared against hand-written per-cycle tables.
module tb_control_sequencer;

  // Control word bit positions (LSB first)
  localparam logic [28:0] MEN  = 29'd1 << 0;
  localparam logic [28:0] MWR  = 29'd1 << 1;
  localparam logic [28:0] MRD  = 29'd1 << 2;
  localparam logic [28:0] INC  = 29'd1 << 3;
  localparam logic [28:0] BAO  = 29'd1 << 4;
  localparam logic [28:0] ROUT = 29'd1 << 5;
  localparam logic [28:0] RIN  = 29'd1 << 6;
  localparam logic [28:0] GRC  = 29'd1 << 7;
  localparam logic [28:0] GRB  = 29'd1 << 8;
  localparam logic [28:0] GRA  = 29'd1 << 9;
  localparam logic [28:0] CONI = 29'd1 << 10;
  localparam logic [28:0] OUTI = 29'd1 << 11;
  localparam logic [28:0] LOI  = 29'd1 << 12;
  localparam logic [28:0] HII  = 29'd1 << 13;
  localparam logic [28:0] YI   = 29'd1 << 14;
  localparam logic [28:0] IRI  = 29'd1 << 15;
  localparam logic [28:0] MDRI = 29'd1 << 16;
  localparam logic [28:0] PCI  = 29'd1 << 17;
  localparam logic [28:0] ZI   = 29'd1 << 18;
  localparam logic [28:0] MARI = 29'd1 << 19;
  localparam logic [28:0] CO   = 29'd1 << 20;
  localparam logic [28:0] INPO = 29'd1 << 21;
  localparam logic [28:0] MDRO = 29'd1 << 22;
  localparam logic [28:0] PCO  = 29'd1 << 23;
  localparam logic [28:0] ZLO  = 29'd1 << 24;
  localparam logic [28:0] ZHO  = 29'd1 << 25;
  localparam logic [28:0] LOO  = 29'd1 << 26;
  localparam logic [28:0] HIO  = 29'd1 << 27;
  localparam logic [28:0] RUN  = 29'd1 << 28;

  localparam logic [31:0] IR_ADD  = 32'h18918000;
  localparam logic [31:0] IR_LD   = 32'h00900055;
  localparam logic [31:0] IR_BR   = 32'h98800004;
  localparam logic [31:0] IR_HALT = 32'hD8000000;
  localparam logic [31:0] IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_MUL  = 32'h80980000;
  localparam logic [31:0] IR_JR   = 32'hA8800000;

  logic        Clock;
  logic [1:0]  clear;
  logic [31:0] IR [2];
  logic [1:0]  con_ff_bit;
  logic [1:0]  Stop;

  wire [1:0] Run, HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
  wire [1:0] MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, outport_in, CONin;
  wire [1:0] Gra, Grb, Grc, Rin, Rout, BAout, IncPC, Mem_Read, Mem_Write, Mem_enable512x32;
  wire [4:0] opcode0, opcode1;

  int tests = 0;
  int fails = 0;

  control_sequencer #(.DATA_WIDTH(32), .OPCODE_WIDTH(5), .MEM_WAIT(1)) u_mw1 (
    .Clock(Clock), .clear(clear[0]), .IR(IR[0]), .con_ff_bit(con_ff_bit[0]), .Stop(Stop[0]),
    .Run(Run[0]), .HIout(HIout[0]), .LOout(LOout[0]), .Zhi_out(Zhi_out[0]),
    .Zlo_out(Zlo_out[0]), .PCout(PCout[0]), .MDRout(MDRout[0]), .Inport_out(Inport_out[0]),
    .Cout(Cout[0]), .MARin(MARin[0]), .Zin(Zin[0]), .PCin(PCin[0]), .MDRin(MDRin[0]),
    .IRin(IRin[0]), .Yin(Yin[0]), .HIin(HIin[0]), .LOin(LOin[0]), .outport_in(outport_in[0]),
    .CONin(CONin[0]), .Gra(Gra[0]), .Grb(Grb[0]), .Grc(Grc[0]), .Rin(Rin[0]), .Rout(Rout[0]),
    .BAout(BAout[0]), .opcode(opcode0), .IncPC(IncPC[0]), .Mem_Read(Mem_Read[0]),
    .Mem_Write(Mem_Write[0]), .Mem_enable512x32(Mem_enable512x32[0])
  );

  control_sequencer #(.DATA_WIDTH(32), .OPCODE_WIDTH(5), .MEM_WAIT(2)) u_mw2 (
    .Clock(Clock), .clear(clear[1]), .IR(IR[1]), .con_ff_bit(con_ff_bit[1]), .Stop(Stop[1]),
    .Run(Run[1]), .HIout(HIout[1]), .LOout(LOout[1]), .Zhi_out(Zhi_out[1]),
    .Zlo_out(Zlo_out[1]), .PCout(PCout[1]), .MDRout(MDRout[1]), .Inport_out(Inport_out[1]),
    .Cout(Cout[1]), .MARin(MARin[1]), .Zin(Zin[1]), .PCin(PCin[1]), .MDRin(MDRin[1]),
    .IRin(IRin[1]), .Yin(Yin[1]), .HIin(HIin[1]), .LOin(LOin[1]), .outport_in(outport_in[1]),
    .CONin(CONin[1]), .Gra(Gra[1]), .Grb(Grb[1]), .Grc(Grc[1]), .Rin(Rin[1]), .Rout(Rout[1]),
    .BAout(BAout[1]), .opcode(opcode1), .IncPC(IncPC[1]), .Mem_Read(Mem_Read[1]),
    .Mem_Write(Mem_Write[1]), .Mem_enable512x32(Mem_enable512x32[1])
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Observed {opcode, control word} of instance i
  function automatic logic [33:0] obs(input int i);
    return {(i == 0) ? opcode0 : opcode1,
            Run[i], HIout[i], LOout[i], Zhi_out[i], Zlo_out[i], PCout[i], MDRout[i],
            Inport_out[i], Cout[i], MARin[i], Zin[i], PCin[i], MDRin[i], IRin[i], Yin[i],
            HIin[i], LOin[i], outport_in[i], CONin[i], Gra[i], Grb[i], Grc[i], Rin[i],
            Rout[i], BAout[i], IncPC[i], Mem_Read[i], Mem_Write[i], Mem_enable512x32[i]};
  endfunction

  function automatic logic [33:0] w(input logic [4:0] op, input logic [28:0] c);
    return {op, c};
  endfunction

  // At most one source may drive the shared bus in any cycle
  always @(negedge Clock) begin
    for (int i = 0; i < 2; i++) begin
      tests++;
      if ($countones({HIout[i], LOout[i], Zhi_out[i], Zlo_out[i], PCout[i], MDRout[i],
                      Inport_out[i], Cout[i], Rout[i], BAout[i]}) > 1) begin
        fails++;
        $display("FAIL bus_single inst%0d t=%0t drivers=%0d required<=1", i, $time,
                 $countones({HIout[i], LOout[i], Zhi_out[i], Zlo_out[i], PCout[i], MDRout[i],
                             Inport_out[i], Cout[i], Rout[i], BAout[i]}));
      end
    end
  end

  task automatic pulse_clear(input int i);
    @(negedge Clock);
    clear[i] = 1'b0;
    repeat (3) @(negedge Clock);
    clear[i] = 1'b1;
  endtask

  task automatic test_reset();
    logic [33:0] exp_f0;
    exp_f0 = w(5'd0, RUN | PCO | MARI | INC | ZI);
    @(negedge Clock);
    clear = 2'b00;
    IR[0] = 'x;
    IR[1] = 'x;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (obs(i) !== 34'd0) begin
          fails++;
          $display("FAIL reset_idle inst%0d c%0d got=%h required=%h", i, c, obs(i), 34'd0);
        end
      end
    end
    clear = 2'b11;
    @(negedge Clock);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (obs(i) !== exp_f0) begin
        fails++;
        $display("FAIL reset_first_f0 inst%0d got=%h required=%h", i, obs(i), exp_f0);
      end
    end
  endtask

  task automatic test_add_mw1();
    logic [33:0] exp [8];
    exp[0] = w(5'd0, RUN | PCO | MARI | INC | ZI);
    exp[1] = w(5'd0, RUN | ZLO | PCI | MRD | MEN);
    exp[2] = w(5'd0, RUN | MRD | MEN | MDRI);
    exp[3] = w(5'd0, RUN | MDRO | IRI);
    exp[4] = w(5'd0, RUN | GRB | ROUT | YI);
    exp[5] = w(5'b00011, RUN | GRC | ROUT | ZI);
    exp[6] = w(5'd0, RUN | ZLO | GRA | RIN);
    exp[7] = w(5'd0, RUN | PCO | MARI | INC | ZI);
    IR[0] = IR_ADD;
    Stop[0] = 1'b0;
    pulse_clear(0);
    for (int c = 0; c < 8; c++) begin
      @(negedge Clock);
      tests++;
      if (obs(0) !== exp[c]) begin
        fails++;
        $display("FAIL add_mw1 c%0d got=%h required=%h", c, obs(0), exp[c]);
      end
    end
  endtask

  task automatic test_ld_mw2();
    logic [33:0] exp [13];
    exp[0]  = w(5'd0, RUN | PCO | MARI | INC | ZI);
    exp[1]  = w(5'd0, RUN | ZLO | PCI | MRD | MEN);
    exp[2]  = w(5'd0, RUN | MRD | MEN);
    exp[3]  = w(5'd0, RUN | MRD | MEN | MDRI);
    exp[4]  = w(5'd0, RUN | MDRO | IRI);
    exp[5]  = w(5'd0, RUN | GRB | BAO | YI);
    exp[6]  = w(5'b00011, RUN | CO | ZI);
    exp[7]  = w(5'd0, RUN | ZLO | MARI);
    exp[8]  = w(5'd0, RUN | MRD | MEN);
    exp[9]  = w(5'd0, RUN | MRD | MEN);
    exp[10] = w(5'd0, RUN | MRD | MEN | MDRI);
    exp[11] = w(5'd0, RUN | MDRO | GRA | RIN);
    exp[12] = w(5'd0, RUN | PCO | MARI | INC | ZI);
    IR[1] = IR_LD;
    Stop[1] = 1'b0;
    pulse_clear(1);
    for (int c = 0; c < 13; c++) begin
      @(negedge Clock);
      tests++;
      if (obs(1) !== exp[c]) begin
        fails++;
        $display("FAIL ld_mw2 c%0d got=%h required=%h", c, obs(1), exp[c]);
      end
    end
  endtask

  task automatic test_branch();
    logic [33:0] exp [8];
    logic [33:0] e;
    exp[0] = w(5'd0, RUN | PCO | MARI | INC | ZI);
    exp[1] = w(5'd0, RUN | ZLO | PCI | MRD | MEN);
    exp[2] = w(5'd0, RUN | MRD | MEN | MDRI);
    exp[3] = w(5'd0, RUN | MDRO | IRI);
    exp[4] = w(5'd0, RUN | GRA | ROUT | CONI);
    exp[5] = w(5'd0, RUN | PCO | YI);
    exp[6] = w(5'b00011, RUN | CO | ZI);
    exp[7] = w(5'd0, RUN | ZLO);
    IR[0] = IR_BR;
    con_ff_bit[0] = 1'b0;
    Stop[0] = 1'b0;
    pulse_clear(0);
    for (int c = 0; c < 17; c++) begin
      @(negedge Clock);
      if (c == 16) e = exp[0];
      else if (c == 15) e = exp[7] | w(5'd0, PCI);
      else e = exp[c % 8];
      tests++;
      if (obs(0) !== e) begin
        fails++;
        $display("FAIL branch c%0d con=%0b got=%h required=%h", c, con_ff_bit[0], obs(0), e);
      end
      if (c == 7) con_ff_bit[0] = 1'b1;
    end
    con_ff_bit[0] = 1'b0;
  endtask

  task automatic test_halt();
    logic [33:0] exp [4];
    exp[0] = w(5'd0, RUN | PCO | MARI | INC | ZI);
    exp[1] = w(5'd0, RUN | ZLO | PCI | MRD | MEN);
    exp[2] = w(5'd0, RUN | MRD | MEN | MDRI);
    exp[3] = w(5'd0, RUN | MDRO | IRI);
    IR[0] = IR_HALT;
    Stop[0] = 1'b0;
    pulse_clear(0);
    for (int c = 0; c < 24; c++) begin
      @(negedge Clock);
      tests++;
      if (obs(0) !== ((c < 4) ? exp[c] : 34'd0)) begin
        fails++;
        $display("FAIL halt_op c%0d got=%h required=%h", c, obs(0), (c < 4) ? exp[c] : 34'd0);
      end
      if (c == 10) IR[0] = IR_ADD;
    end
  endtask

  task automatic test_stop_mid_add();
    logic [33:0] exp [10];
    exp[0] = w(5'd0, RUN | PCO | MARI | INC | ZI);
    exp[1] = w(5'd0, RUN | ZLO | PCI | MRD | MEN);
    exp[2] = w(5'd0, RUN | MRD | MEN | MDRI);
    exp[3] = w(5'd0, RUN | MDRO | IRI);
    exp[4] = w(5'd0, RUN | GRB | ROUT | YI);
    exp[5] = w(5'b00011, RUN | GRC | ROUT | ZI);
    exp[6] = w(5'd0, RUN | ZLO | GRA | RIN);
    exp[7] = 34'd0;
    exp[8] = 34'd0;
    exp[9] = 34'd0;
    IR[0] = IR_ADD;
    Stop[0] = 1'b0;
    pulse_clear(0);
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock);
      tests++;
      if (obs(0) !== exp[c]) begin
        fails++;
        $display("FAIL stop_mid_add c%0d got=%h required=%h", c, obs(0), exp[c]);
      end
      if (c == 4) Stop[0] = 1'b1;
      if (c == 7) Stop[0] = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] exp [18];
    exp[0]  = w(5'd0, RUN | PCO | MARI | INC | ZI);
    exp[1]  = w(5'd0, RUN | ZLO | PCI | MRD | MEN);
    exp[2]  = w(5'd0, RUN | MRD | MEN | MDRI);
    exp[3]  = w(5'd0, RUN | MDRO | IRI);
    exp[4]  = exp[0];
    exp[5]  = exp[1];
    exp[6]  = exp[2];
    exp[7]  = exp[3];
    exp[8]  = w(5'd0, RUN | GRA | ROUT | YI);
    exp[9]  = w(5'b10000, RUN | GRB | ROUT | ZI);
    exp[10] = w(5'd0, RUN | ZLO | LOI);
    exp[11] = w(5'd0, RUN | ZHO | HII);
    exp[12] = exp[0];
    exp[13] = exp[1];
    exp[14] = exp[2];
    exp[15] = exp[3];
    exp[16] = w(5'd0, RUN | GRA | ROUT | PCI);
    exp[17] = exp[0];
    IR[0] = IR_NOP;
    Stop[0] = 1'b0;
    pulse_clear(0);
    for (int c = 0; c < 18; c++) begin
      @(negedge Clock);
      tests++;
      if (obs(0) !== exp[c]) begin
        fails++;
        $display("FAIL back_to_back c%0d got=%h required=%h", c, obs(0), exp[c]);
      end
      if (c == 4) IR[0] = IR_MUL;
      if (c == 12) IR[0] = IR_JR;
    end
  endtask

  task automatic test_clear_mid_ld();
    logic [33:0] exp [10];
    exp[0] = w(5'd0, RUN | PCO | MARI | INC | ZI);
    exp[1] = w(5'd0, RUN | ZLO | PCI | MRD | MEN);
    exp[2] = w(5'd0, RUN | MRD | MEN);
    exp[3] = w(5'd0, RUN | MRD | MEN | MDRI);
    exp[4] = w(5'd0, RUN | MDRO | IRI);
    exp[5] = w(5'd0, RUN | GRB | BAO | YI);
    exp[6] = w(5'b00011, RUN | CO | ZI);
    exp[7] = w(5'd0, RUN | ZLO | MARI);
    exp[8] = w(5'd0, RUN | MRD | MEN);
    exp[9] = w(5'd0, RUN | MRD | MEN);
    IR[1] = IR_LD;
    Stop[1] = 1'b0;
    pulse_clear(1);
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock);
      tests++;
      if (obs(1) !== exp[c]) begin
        fails++;
        $display("FAIL clear_ld_pre c%0d got=%h required=%h", c, obs(1), exp[c]);
      end
    end
    #1 clear[1] = 1'b0;
    #1;
    tests++;
    if (obs(1) !== 34'd0) begin
      fails++;
      $display("FAIL clear_ld_async got=%h required=%h", obs(1), 34'd0);
    end
    repeat (2) @(negedge Clock);
    clear[1] = 1'b1;
    @(negedge Clock);
    tests++;
    if (obs(1) !== exp[0]) begin
      fails++;
      $display("FAIL clear_ld_restart_f0 got=%h required=%h", obs(1), exp[0]);
    end
    @(negedge Clock);
    tests++;
    if (obs(1) !== exp[1]) begin
      fails++;
      $display("FAIL clear_ld_restart_f1 got=%h required=%h", obs(1), exp[1]);
    end
  endtask

  initial begin
    clear      = 2'b00;
    IR[0]      = 32'd0;
    IR[1]      = 32'd0;
    con_ff_bit = 2'b00;
    Stop       = 2'b00;
    test_reset();
    test_add_mw1();
    test_ld_mw2();
    test_branch();
    test_halt();
    test_stop_mid_add();
    test_back_to_back();
    test_clear_mid_ld();
    @(posedge Clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
